// File: rtl/mcu_core_nbit.sv
// mcu_core_nbit -- parametrised accumulator MCU core.
//
// Fetches one instruction per request over a req/valid handshake, then
// executes it in a single EXEC cycle against the accumulator, register file
// and Z/C flags. FSM: IDLE -> FETCH -> EXEC -> FETCH ... -> HALT.
//
// Parameters:
//   DATA_W  accumulator / register / ALU width
//   REG_AW  register-file address width (2^REG_AW registers), operand width
//   PC_W    program-counter width (must be >= REG_AW)
//
// Ports:
//   Clk         system clock, rising edge
//   Reset       asynchronous active-low reset
//   pc_clr      synchronous restart: PC <- 0, state <- FETCH
//   imem_req    fetch request (high in FETCH)
//   imem_addr   fetch address (current PC)
//   imem_valid  instruction data valid (only sampled in FETCH)
//   imem_data   instruction word {opcode[3:0], operand[REG_AW-1:0]}
//   acc_out     accumulator
//   flag_z      zero flag
//   flag_c      carry / borrow flag
//   halted      high while in HALT
//
// Optional feature (macro MCU_RETIRE_EN):
//   retire      one-cycle pulse after each completed EXEC
//   retire_pc   fetch address of the retired instruction
module mcu_core_nbit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned PC_W   = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pc_clr,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [REG_AW+3:0] imem_data,
    output logic [DATA_W-1:0] acc_out,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted
`ifdef MCU_RETIRE_EN
    ,
    output logic              retire,
    output logic [PC_W-1:0]   retire_pc
`endif
);

    localparam int unsigned NREG = 1 << REG_AW;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LDR = 4'h2, OP_STR = 4'h3,
        OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
        OP_XOR = 4'h8, OP_NOT = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
        OP_JMP = 4'hC, OP_JMPR = 4'hD, OP_JZ = 4'hE, OP_HLT = 4'hF
    } op_t;

    state_t              r_state, w_next;
    logic [PC_W-1:0]     r_pc;
    logic [REG_AW+3:0]   r_ir;
    logic [DATA_W-1:0]   r_acc;
    logic                r_z, r_c;
    logic [DATA_W-1:0]   r_regs [NREG];

    op_t                 w_op;
    logic [REG_AW-1:0]   w_opnd;
    logic [DATA_W-1:0]   w_rdat;
    logic [DATA_W-1:0]   w_acc_n;
    logic [DATA_W:0]     w_sum;
    logic                w_z_n, w_c_n, w_flag_upd;
    logic                w_wr, w_jmp;
    logic [PC_W-1:0]     w_jpc;

    assign w_op   = op_t'(r_ir[REG_AW+3:REG_AW]);
    assign w_opnd = r_ir[REG_AW-1:0];
    assign w_rdat = r_regs[w_opnd];

    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign halted    = (r_state == S_HALT);
    assign acc_out   = r_acc;
    assign flag_z    = r_z;
    assign flag_c    = r_c;

    // Execute datapath: results are only committed when r_state == S_EXEC.
    always_comb begin
        w_acc_n    = r_acc;
        w_sum      = '0;
        w_c_n      = r_c;
        w_z_n      = r_z;
        w_flag_upd = 1'b0;
        w_wr       = 1'b0;
        w_jmp      = 1'b0;
        w_jpc      = r_pc;
        case (w_op)
            OP_NOP: ;
            OP_LDI: w_acc_n = DATA_W'(w_opnd);
            OP_LDR: w_acc_n = w_rdat;
            OP_STR: w_wr = 1'b1;
            OP_ADD: begin
                w_sum      = {1'b0, r_acc} + {1'b0, w_rdat};
                w_acc_n    = w_sum[DATA_W-1:0];
                w_c_n      = w_sum[DATA_W];
                w_flag_upd = 1'b1;
            end
            OP_SUB: begin
                // Zero-extended difference: the extra top bit is the borrow.
                w_sum      = {1'b0, r_acc} - {1'b0, w_rdat};
                w_acc_n    = w_sum[DATA_W-1:0];
                w_c_n      = w_sum[DATA_W];
                w_flag_upd = 1'b1;
            end
            OP_AND: begin w_acc_n = r_acc & w_rdat; w_c_n = 1'b0; w_flag_upd = 1'b1; end
            OP_OR:  begin w_acc_n = r_acc | w_rdat; w_c_n = 1'b0; w_flag_upd = 1'b1; end
            OP_XOR: begin w_acc_n = r_acc ^ w_rdat; w_c_n = 1'b0; w_flag_upd = 1'b1; end
            OP_NOT: begin w_acc_n = ~r_acc;         w_c_n = 1'b0; w_flag_upd = 1'b1; end
            OP_SHL: begin w_acc_n = r_acc << 1; w_c_n = r_acc[DATA_W-1]; w_flag_upd = 1'b1; end
            OP_SHR: begin w_acc_n = r_acc >> 1; w_c_n = r_acc[0];        w_flag_upd = 1'b1; end
            OP_JMP:  begin w_jmp = 1'b1; w_jpc = PC_W'(w_opnd); end
            // Cast truncates or zero-extends the register to PC width.
            OP_JMPR: begin w_jmp = 1'b1; w_jpc = PC_W'(w_rdat); end
            OP_JZ:   begin w_jmp = r_z;  w_jpc = PC_W'(w_opnd); end
            OP_HLT: ;
            default: ;
        endcase
        if (w_flag_upd) begin
            w_z_n = (w_acc_n == '0);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_FETCH;
            S_FETCH: if (imem_valid) w_next = S_EXEC;
            S_EXEC:  w_next = (w_op == OP_HLT) ? S_HALT : S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
        if (pc_clr) begin
            w_next = S_FETCH;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef MCU_RETIRE_EN
    logic [PC_W-1:0] r_ir_pc;
    logic            r_retire;
    logic [PC_W-1:0] r_retire_pc;
    assign retire    = r_retire;
    assign retire_pc = r_retire_pc;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_ir_pc     <= '0;
            r_retire    <= 1'b0;
            r_retire_pc <= '0;
        end else begin
            r_retire <= 1'b0;
            if (!pc_clr) begin
                if (r_state == S_FETCH && imem_valid) begin
                    r_ir_pc <= r_pc;
                end
                if (r_state == S_EXEC) begin
                    r_retire    <= 1'b1;
                    r_retire_pc <= r_ir_pc;
                end
            end
        end
    end
`endif

    // pc_clr suppresses both the fetch capture and the EXEC commit.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_acc <= '0;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (pc_clr) begin
            r_pc <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_valid) begin
                        r_ir <= imem_data;
                        r_pc <= r_pc + PC_W'(1);
                    end
                end
                S_EXEC: begin
                    r_acc <= w_acc_n;
                    r_z   <= w_z_n;
                    r_c   <= w_c_n;
                    if (w_wr) begin
                        r_regs[w_opnd] <= r_acc;
                    end
                    if (w_jmp) begin
                        r_pc <= w_jpc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mcu_core_nbit.md
# mcu_core_nbit

Parametrised successor to the 8-bit accumulator MCU.
- Integrates instruction register, program counter, fetch/execute FSM, register file, ALU, accumulator and Z/C flags in one core.
- Fetches from an external instruction memory over a req/valid handshake.
- Data width, register count and PC width are generic.
- Adds instructions the 8-bit generation lacks: halt, conditional jump, register jump, shifts.

## Interface
Parameters:
- DATA_W, 8, width of accumulator, registers and ALU.
- REG_AW, 4, register-file address width; the file holds 2^REG_AW registers. Also the operand-field width.
- PC_W, 8, program-counter width; must be ≥ REG_AW.

Ports (clock and reset first):
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- pc_clr  in  1  synchronous restart, active high.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address; equals the current PC.
- imem_valid  in  1  instruction data valid; ignored while imem_req is low.
- imem_data  in  4+REG_AW  instruction word; opcode is [REG_AW+3:REG_AW], operand is [REG_AW-1:0].
- acc_out  out  DATA_W  accumulator value.
- flag_z, flag_c  out  1 each  registered zero and carry flags.
- halted  out  1  high while the core is in HALT.

## Operation
Opcodes. "op" is the operand field, zero-extended wherever it is used as a value.
- 0 NOP: no effect.
- 1 LDI: ACC ← op.
- 2 LDR: ACC ← R[op].
- 3 STR: R[op] ← ACC.
- 4 ADD: ACC ← ACC+R[op]; C = carry out.
- 5 SUB: ACC ← ACC−R[op]; C = borrow.
- 6 AND, 7 OR, 8 XOR: ACC ← ACC op R[op]; C ← 0.
- 9 NOT: ACC ← ~ACC; C ← 0.
- A SHL: shift left one bit, fill with 0; C = old MSB.
- B SHR: shift right one bit, fill with 0; C = old LSB.
- C JMP: PC ← op.
- D JMPR: PC ← R[op][PC_W-1:0] when DATA_W ≥ PC_W, otherwise R[op] zero-extended.
- E JZ: PC ← op if flag_z = 1, otherwise no effect.
- F HLT: enter HALT.

Flags:
- Z is updated only by opcodes 4–B: Z = (result == 0).
- C is updated only by opcodes 4–B, as listed above.
- All other opcodes leave both flags unchanged.

Arithmetic and width rules:
- All arithmetic is modulo 2^DATA_W.
- The PC increments modulo 2^PC_W, so the fetch at address 2^PC_W−1 wraps to 0.
- For STR immediately followed by LDR of the same register, LDR reads the newly written value.

FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE: the state after reset. Always → FETCH on the next cycle.
- FETCH: imem_req = 1 and imem_addr = PC, both held stable until imem_valid is seen.
  - On imem_valid: IR ← imem_data, PC ← PC+1, → EXEC.
- EXEC: executes IR in one cycle.
  - HLT → HALT.
  - Every other opcode → FETCH.
  - A taken jump overrides the increment already applied to PC.
- HALT: imem_req = 0 and halted = 1. Stays in HALT until pc_clr or Reset.

pc_clr:
- Acts in any state: PC ← 0, state ← FETCH.
- Any outstanding fetch is abandoned, and an imem_valid in the same cycle is discarded.
- ACC, the register file and the flags are preserved.
- pc_clr takes priority over all FSM transitions; only Reset outranks it.

## Timing
Reset values (applied asynchronously while Reset = 0):
- PC = 0, IR = 0, ACC = 0, all registers = 0, flags = 0, state = IDLE.
- imem_req = 0, halted = 0.
- With MCU_RETIRE_EN defined: retire = 0, retire_pc = 0.

Cycle-level behaviour:
- The first imem_req is asserted in the 2nd rising-edge cycle after Reset deasserts.
- Instruction cost is 2 cycles when imem_valid arrives in the same cycle as the request; each cycle of wait-state adds one cycle.
- Results of EXEC (ACC, flags, registers, PC) are visible on outputs the cycle after EXEC.
- Reset asserted mid-fetch or mid-execute aborts immediately; no partial register write takes effect.

## Configuration
MCU_RETIRE_EN:
- Defined: adds output ports retire (1 bit) and retire_pc (PC_W bits).
  - retire pulses high for exactly one cycle following each EXEC.
  - retire_pc is the address the retired instruction was fetched from.
  - HLT retires once.
  - An EXEC cut short by pc_clr does not retire.
- Undefined: both ports are absent and no retire logic is present.

## Test plan
- Reset, then 0-wait memory with program LDI 5; STR R2; LDI 3; ADD R2; HLT → acc_out = 8, Z = 0, C = 0, halted = 1 after 10 cycles of fetch/exec, imem_req = 0 thereafter.
- DATA_W = 8: LDI 15; STR R1; LDI 1; SHL ×4 (ACC = 16); ADD R1 repeated until overflow → on the wrap, carry is set (e.g. 0xFF+0x01 gives ACC = 0, Z = 1, C = 1). Then SUB from 0 → ACC = 0xFF, C = 1 (borrow).
- JZ taken and not taken: LDI 0; AND R0 (Z = 1); JZ 9 → next fetch at 9. With Z = 0, JZ 9 falls through to PC+1.
- imem_valid delayed 3 cycles on every fetch → imem_addr stays stable throughout the wait, one instruction executes per 5 cycles, and results match the 0-wait run.
- pc_clr pulsed during a wait-state fetch at PC = 6, and again while in HALT → next imem_addr = 0, ACC and flags unchanged, halted drops the cycle after pc_clr.
- PC_W = 4, straight NOP program → PC wraps 15 → 0. Under MCU_RETIRE_EN, retire pulses once per instruction with retire_pc = 15 then 0.
